// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle control FSM for the RV32 subset datapath
//            (LW, SW, OP-IMM, BEQ, R-type). Optional MEM wait timeout is
//            enabled with the CTRL_MEM_TIMEOUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter logic [2:0] INITIAL_STATE = 3'd0,
    parameter logic [6:0] SW            = 7'b0100011,
    parameter logic [6:0] LW            = 7'b0000011,
    parameter logic [6:0] IMMEDIATE     = 7'b0010011,
    parameter logic [6:0] BEQ           = 7'b1100011,
    parameter logic [6:0] RR            = 7'b0110011,
    parameter int         MEM_TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        dmem_ready,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        loadPC,
    output logic [3:0]  ALUCtrl,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        illegal,
    output logic        mem_err,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SLL = 4'b0011;
    localparam logic [3:0] c_ALU_SRL = 4'b0100;
    localparam logic [3:0] c_ALU_SRA = 4'b0101;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_XOR = 4'b1000;

    state_t      r_state;
    state_t      w_next_state;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [31:0] r_instr_cnt;

    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_imm;
    logic        w_is_beq;
    logic        w_is_rr;
    logic        w_legal;
    logic        w_uses_imm;
    logic [3:0]  w_alu_dec;
    logic        w_timeout;
    logic        w_unused;

    assign w_is_lw    = (r_opcode == LW);
    assign w_is_sw    = (r_opcode == SW);
    assign w_is_imm   = (r_opcode == IMMEDIATE);
    assign w_is_beq   = (r_opcode == BEQ);
    assign w_is_rr    = (r_opcode == RR);
    assign w_legal    = w_is_lw | w_is_sw | w_is_imm | w_is_beq | w_is_rr;
    assign w_uses_imm = w_is_lw | w_is_sw | w_is_imm;

    // Register fields and the rest of the immediate live in the datapath.
    assign w_unused = ^{instr[24:15], instr[11:7], r_funct7[6], r_funct7[4:0]}
                      ^ (MEM_TIMEOUT == 0);

    assign state     = r_state;
    assign instr_cnt = r_instr_cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= state_t'(INITIAL_STATE);
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction register: only the fields the control decode needs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= 7'd0;
            r_funct3 <= 3'd0;
            r_funct7 <= 7'd0;
        end else if (r_state == S_IF) begin
            r_opcode <= instr[6:0];
            r_funct3 <= instr[14:12];
            r_funct7 <= instr[31:25];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_cnt <= 32'd0;
        end else if (loadPC) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    // EX is the only path into MEM, so clearing there clears on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == S_EX) begin
            r_wait_cnt <= 8'd0;
        end else if ((r_state == S_MEM) && !dmem_ready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == S_MEM) && !dmem_ready &&
                       (r_wait_cnt == 8'(MEM_TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    // ALU operation from the latched IR
    always_comb begin
        w_alu_dec = c_ALU_ADD;
        if (w_is_beq) begin
            w_alu_dec = c_ALU_SUB;
        end else if (w_is_rr || w_is_imm) begin
            case (r_funct3)
                3'b000:  w_alu_dec = (w_is_rr && r_funct7[5]) ? c_ALU_SUB : c_ALU_ADD;
                3'b111:  w_alu_dec = c_ALU_AND;
                3'b110:  w_alu_dec = c_ALU_OR;
                3'b100:  w_alu_dec = c_ALU_XOR;
                3'b010:  w_alu_dec = c_ALU_SLT;
                3'b001:  w_alu_dec = c_ALU_SLL;
                3'b101:  w_alu_dec = r_funct7[5] ? c_ALU_SRA : c_ALU_SRL;
                default: w_alu_dec = c_ALU_ADD;
            endcase
        end
    end

    // Next state and control outputs
    always_comb begin
        w_next_state = S_IF;
        PCSrc        = 1'b0;
        ALUSrc       = 1'b0;
        RegWrite     = 1'b0;
        MemToReg     = 1'b0;
        loadPC       = 1'b0;
        ALUCtrl      = c_ALU_ADD;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        illegal      = 1'b0;
        mem_err      = 1'b0;

        case (r_state)
            S_IF: begin
                w_next_state = S_ID;
            end
            S_ID: begin
                if (w_legal) begin
                    w_next_state = S_EX;
                end else begin
                    loadPC       = 1'b1;
                    illegal      = 1'b1;
                    w_next_state = S_IF;
                end
            end
            S_EX: begin
                ALUSrc  = w_uses_imm;
                ALUCtrl = w_alu_dec;
                if (w_is_lw || w_is_sw) begin
                    w_next_state = S_MEM;
                end else if (w_is_beq) begin
                    loadPC       = 1'b1;
                    PCSrc        = Zero;
                    w_next_state = S_IF;
                end else if (w_is_rr || w_is_imm) begin
                    w_next_state = S_WB;
                end else begin
                    w_next_state = S_IF;
                end
            end
            S_MEM: begin
                ALUSrc  = w_uses_imm;
                ALUCtrl = w_alu_dec;
                if (w_timeout) begin
                    mem_err      = 1'b1;
                    loadPC       = 1'b1;
                    w_next_state = S_IF;
                end else begin
                    MemRead  = w_is_lw;
                    MemWrite = w_is_sw;
                    if (!dmem_ready) begin
                        w_next_state = S_MEM;
                    end else if (w_is_lw) begin
                        w_next_state = S_WB;
                    end else begin
                        loadPC       = 1'b1;
                        w_next_state = S_IF;
                    end
                end
            end
            S_WB: begin
                ALUSrc       = w_uses_imm;
                ALUCtrl      = w_alu_dec;
                RegWrite     = 1'b1;
                MemToReg     = w_is_lw;
                loadPC       = 1'b1;
                w_next_state = S_IF;
            end
            default: begin
                w_next_state = S_IF;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that sequences the RV32 subset datapath (LW, SW, OP-IMM, BEQ, R-type) through fetch, decode, execute, memory and write-back. It drives the datapath control inputs PCSrc, ALUSrc, RegWrite, MemToReg, loadPC and ALUCtrl. It also drives the data-memory read/write strobes and waits on a memory ready handshake. It sits beside the datapath in the CPU top level, and is the only block that asserts loadPC.

## Interface
- INITIAL_STATE, 3'd0, state code entered on reset (IF).
- SW, 7'b0100011, store opcode.
- LW, 7'b0000011, load opcode.
- IMMEDIATE, 7'b0010011, OP-IMM opcode.
- BEQ, 7'b1100011, branch opcode.
- RR, 7'b0110011, register-register opcode.
- MEM_TIMEOUT, 8, maximum MEM wait cycles (used only with CTRL_MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  32  current instruction word; valid during IF.
- Zero  in  1  ALU zero flag from the datapath.
- dmem_ready  in  1  data memory completes the access this cycle.
- PCSrc  out  1  selects the branch target on a loadPC cycle.
- ALUSrc  out  1  op2 = immediate when 1.
- RegWrite  out  1  register file write enable.
- MemToReg  out  1  write-back source is memory read data.
- loadPC  out  1  PC update strobe, one cycle per instruction.
- ALUCtrl  out  4  ALU operation.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- mem_err  out  1  one-cycle pulse on a MEM timeout (macro only; tied 0 otherwise).
- state  out  3  current state, for debug.
- instr_cnt  out  32  retired-instruction counter; wraps 0xFFFFFFFF -> 0.

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5-7 go to IF on the next clock.
- IF: capture instr[6:0], [14:12] and [31:25] into an internal IR, then go to ID.
- ID:
  - Legal opcode: go to EX.
  - Illegal opcode: assert loadPC (PCSrc=0) and illegal, then go to IF.
- EX:
  - LW/SW: go to MEM.
  - RR/IMMEDIATE: go to WB.
  - BEQ: assert loadPC with PCSrc=Zero, then go to IF.
- MEM:
  - LW holds MemRead=1; SW holds MemWrite=1.
  - Stay in MEM while dmem_ready=0.
  - On dmem_ready=1: LW goes to WB; SW asserts loadPC and goes to IF.
- WB: assert RegWrite=1, MemToReg=(opcode==LW), loadPC=1, then go to IF.
- ALUSrc=1 for LW, SW, IMMEDIATE in EX/MEM/WB; otherwise 0.
- ALUCtrl encoding: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111, XOR 1000.
- ALUCtrl decode from the latched IR:
  - LW, SW: ADD. BEQ: SUB.
  - funct3 000: ADD; SUB only for RR with funct7[5]=1.
  - funct3 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL.
  - funct3 101: SRL, or SRA when funct7[5]=1 (RR and IMMEDIATE).
  - IF/ID and unused funct3 (011): ADD.
- Outputs are combinational from state, latched IR and Zero (PCSrc only). No output depends on instr after IF.
- instr_cnt increments on every clock where loadPC=1, including illegal and timeout skips.

## Timing
- Reset: state=IF and IR=0. All 1-bit outputs are 0, ALUCtrl=0010 and instr_cnt=0.
- Reset mid-instruction aborts it immediately. No loadPC is issued for the aborted instruction.
- Cycles per instruction (zero wait states): BEQ 3, RR/IMM 4, SW 4, LW 5, illegal 2. Each memory wait cycle adds 1 to SW and LW.
- loadPC is high for exactly one cycle per instruction. The datapath PC updates on the rising edge that ends that cycle.
- The MemRead/MemWrite request stays stable until the cycle in which dmem_ready=1, inclusive. It drops on the next cycle.
- dmem_ready outside MEM is ignored.

## Configuration
- CTRL_MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to MEM and increments on each dmem_ready=0 cycle.
  - When the counter reaches MEM_TIMEOUT with dmem_ready still 0, that cycle asserts mem_err and loadPC (PCSrc=0), drops the request, and goes to IF.
  - RegWrite is never asserted for the aborted load.
- CTRL_MEM_TIMEOUT_EN undefined: MEM waits indefinitely and mem_err is tied 0.

## Test plan
- Reset, then RR instr 0x002081B3 (add x3,x1,x2): state sequence 0,1,2,4,0; WB cycle has RegWrite=1, MemToReg=0, loadPC=1, ALUCtrl=0010; instr_cnt=1.
- LW 0x0000A183 with dmem_ready low for 2 MEM cycles: MemRead high for 3 cycles; WB has MemToReg=1; 7 cycles total.
- BEQ 0x00208463: Zero=1 gives PCSrc=1, loadPC=1 in EX, ALUCtrl=0110. Zero=0 gives PCSrc=0; RegWrite never asserted.
- SW 0x0020A023 with dmem_ready=1: MemWrite for 1 cycle, loadPC in the same cycle, ALUSrc=1.
- Opcode 0x7F: illegal=1 and loadPC=1 in ID; back to IF after 2 cycles.
- With CTRL_MEM_TIMEOUT_EN and dmem_ready stuck 0 on LW: mem_err=1 after MEM_TIMEOUT=8 wait cycles, no RegWrite. A separate run asserts rst in MEM and checks all outputs clear asynchronously.
